magnetron_sched: RTL and testbench
==================================

# magnetron_sched

Duty-cycle scheduler for the microwave's magnetron and its auxiliaries (fan, turntable, cavity lamp). It sits beside `ctrl_microondas`, consumes its run state, door switch and power code (4'hA/4'hB/4'hC), and turns the selected power level into a slow PWM. The PWM uses a fixed-length window of one-second ticks. It also enforces the door interlock and a fan overrun after heating stops.

## Interface
- `TICK_CYCLES`, 100_000_000, clock cycles per one-second tick.
- `PERIOD_S`, 10, window length in ticks.
- `ON_LO`, 3, magnetron-on ticks per window for pot 4'hA.
- `ON_MID`, 6, magnetron-on ticks per window for pot 4'hB; pot 4'hC is on for the full `PERIOD_S`.
- `FAN_OVERRUN_S`, 3, fan-only ticks after heating ends.
- Constraint: 1 ≤ `ON_LO` ≤ `ON_MID` ≤ `PERIOD_S` ≤ 255.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `run`  in  1  level; high while the controller is in its ON state.
- `porta`  in  1  door open = 1.
- `pot`  in  4  power code 4'hA/4'hB/4'hC.
- `magnetron`  out  1  magnetron enable.
- `fan`  out  1  cooling fan.
- `turntable`  out  1  turntable motor.
- `lamp`  out  1  cavity lamp.
- `window_start`  out  1  one-cycle pulse when a window begins and `pot` is latched.
- `pot_err`  out  1  latched pot code was invalid.

## Operation
- **States:**
  - IDLE: all outputs off, except `lamp` = `porta`.
  - HEAT_ON: `magnetron`, `fan`, `turntable` and `lamp` on.
  - HEAT_OFF: as HEAT_ON but `magnetron` off.
  - OVERRUN: `fan` on; `magnetron` and `turntable` off; `lamp` = `porta`.
- **Counters:**
  - Prescaler: 0..`TICK_CYCLES`-1; `tick` pulses on the terminal count.
  - `sec_cnt`: 8 bits, position within the window.
  - `ovr_cnt`: overrun counter.
- **Window start:**
  - Entered from IDLE or OVERRUN when `run` & ~`porta`.
  - On every window start: clear prescaler and `sec_cnt`, latch `pot` into `pot_q`, compute `on_ticks`, pulse `window_start`, go to HEAT_ON.
  - `on_ticks` by `pot_q`: A→`ON_LO`, B→`ON_MID`, C→`PERIOD_S`.
  - Invalid `pot_q` code: `on_ticks` = 0, `pot_err` = 1, window runs entirely in HEAT_OFF.
  - `pot_err` is cleared at the next window start with a valid code.
- **Per tick in HEAT_ON/HEAT_OFF:** `sec_cnt`++.
  - When `sec_cnt`+1 == `on_ticks` in HEAT_ON: go to HEAT_OFF.
  - When `sec_cnt`+1 == `PERIOD_S`: new window start (re-latch `pot`).
  - With `pot` 4'hC, HEAT_ON is continuous across windows.
- **`pot` changes mid-window:** ignored until the next window start.
- **Stop:** `run` low or `porta` high in HEAT_ON/HEAT_OFF → OVERRUN with `ovr_cnt` cleared.
  - This has priority over any simultaneous tick or window event.
- **OVERRUN:**
  - Each tick: `ovr_cnt`++; at `FAN_OVERRUN_S` ticks → IDLE.
  - `run` & ~`porta` during OVERRUN → window start; `ovr_cnt` is discarded.
- **Door interlock:**
  - `magnetron` = `mag_q` & ~`porta` & ~`reset`.
  - Door open or reset forces the magnetron off in the same cycle, independent of the state register.
- **`run` rises with `porta` high:** remain in IDLE; start when the door closes while `run` is still high.

## Timing
- Reset values (after the first `reset` edge): state IDLE, all counters 0, `pot_q` = 4'hA.
  - All outputs 0, except `lamp` = `porta`.
- Start latency: `run` sampled high at edge n (door closed) → `magnetron`/`window_start` high in the cycle after edge n.
- `window_start` is high for exactly one cycle.
- HEAT_ON duration = `on_ticks`×`TICK_CYCLES` cycles; the window is exactly `PERIOD_S`×`TICK_CYCLES` cycles.
- The first tick of a window comes `TICK_CYCLES` cycles after its start.
- Stop latency:
  - `run` low → `magnetron` low one cycle after the sampling edge.
  - `porta` high → `magnetron` low combinationally, in the same cycle.
- Overrun length: `FAN_OVERRUN_S` ticks. The prescaler free-runs through OVERRUN and is not cleared on OVERRUN entry, so the first overrun tick may be partial.
- Reset mid-operation: `magnetron` drops immediately (gated); all other outputs go to reset values at the next edge.

## Configuration
- `MAG_SOFTSTART_EN` defined:
  - The first window after leaving IDLE uses `ON_LO` regardless of `pot`; `pot_q` still latches `pot` and `pot_err` is still evaluated.
  - Later windows use `pot_q`.
  - Restart from OVERRUN is not a soft start.
- Undefined: every window uses the latched `pot` immediately.

## Test plan
Parameters for all scenarios: `TICK_CYCLES`=4, `PERIOD_S`=10, `ON_LO`=3, `ON_MID`=6, `FAN_OVERRUN_S`=3, macro undefined unless stated.
- `pot`=4'hB, `run` high for 100 cycles → `magnetron` high 24 cycles, low 16 cycles, repeating; `window_start` at cycles 1, 41, 81.
- `pot`=4'hC → `magnetron` continuously high; `pot` changed to 4'hA at cycle 20 → first window still full-on, next window 12 cycles on / 28 off.
- `porta` raised at cycle 10 of HEAT_ON → `magnetron` low in cycle 10; `fan` high for 12 more cycles, then IDLE; closing the door with `run` high restarts with a `window_start` pulse.
- `pot`=4'h7 → `pot_err`=1, `magnetron` never high, `fan`/`turntable` high; next window with `pot`=4'hA clears `pot_err`.
- `reset` asserted mid-HEAT_ON → `magnetron` low in the same cycle; all outputs 0 after the edge; `run` held high restarts a full window after `reset` drops.
- With `MAG_SOFTSTART_EN` and `pot`=4'hC → first window 12 on / 28 off, second window continuously on.

Source files
------------

// File: rtl/magnetron_sched.sv
// magnetron_sched: slow-PWM duty-cycle scheduler for the magnetron, with
// fan / turntable / lamp sequencing, door interlock and fan overrun.
// Optional feature macro: MAG_SOFTSTART_EN (first window after IDLE is
// forced to the low duty cycle).
module magnetron_sched #(
    parameter int TICK_CYCLES   = 100_000_000,
    parameter int PERIOD_S      = 10,
    parameter int ON_LO         = 3,
    parameter int ON_MID        = 6,
    parameter int FAN_OVERRUN_S = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic       porta,
    input  logic [3:0] pot,
    output logic       magnetron,
    output logic       fan,
    output logic       turntable,
    output logic       lamp,
    output logic       window_start,
    output logic       pot_err
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [7:0] PERIOD_8 = 8'(PERIOD_S);
    localparam logic [7:0] ON_LO_8  = 8'(ON_LO);
    localparam logic [7:0] ON_MID_8 = 8'(ON_MID);
    localparam logic [7:0] FAN_8    = 8'(FAN_OVERRUN_S);

`ifdef MAG_SOFTSTART_EN
    localparam logic SOFTSTART = 1'b1;
`else
    localparam logic SOFTSTART = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HEAT_ON  = 2'd1,
        HEAT_OFF = 2'd2,
        OVERRUN  = 2'd3
    } state_t;

    // True for the three recognised power codes.
    function automatic logic pot_valid_f(input logic [3:0] code);
        case (code)
            4'hA, 4'hB, 4'hC: pot_valid_f = 1'b1;
            default:          pot_valid_f = 1'b0;
        endcase
    endfunction

    // Magnetron-on ticks per window for a power code (0 for invalid codes).
    function automatic logic [7:0] on_ticks_f(input logic [3:0] code);
        case (code)
            4'hA:    on_ticks_f = ON_LO_8;
            4'hB:    on_ticks_f = ON_MID_8;
            4'hC:    on_ticks_f = PERIOD_8;
            default: on_ticks_f = 8'd0;
        endcase
    endfunction

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    sec_q, sec_d;
    logic [7:0]    ovr_q, ovr_d;
    logic [3:0]    pot_q, pot_d;
    logic          err_q, err_d;
    logic          soft_q, soft_d;
    logic          ws_q, ws_d;
    logic          mag_q, mag_d;
    logic          fan_q, fan_d;
    logic          turn_q, turn_d;
    logic          lamp_q, lamp_d;

    logic          tick_s;
    logic          go_s;
    logic          start_s;
    logic [7:0]    on_ticks_s;
    logic [7:0]    on_new_s;
    logic [7:0]    sec_inc_s;
    logic [7:0]    ovr_inc_s;

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        sec_d      = sec_q;
        ovr_d      = ovr_q;
        pot_d      = pot_q;
        err_d      = err_q;
        soft_d     = soft_q;
        ws_d       = 1'b0;
        start_s    = 1'b0;
        on_new_s   = 8'd0;
        tick_s     = (presc_q == TICK_LAST);
        go_s       = run & ~porta;
        on_ticks_s = soft_q ? ON_LO_8 : on_ticks_f(pot_q);
        sec_inc_s  = sec_q + 8'd1;
        ovr_inc_s  = ovr_q + 8'd1;

        // Prescaler free-runs in every state; window start clears it below.
        if (tick_s) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1'b1);
        end

        case (state_q)
            IDLE: begin
                if (go_s) begin
                    start_s = 1'b1;
                    soft_d  = SOFTSTART;
                end else begin
                    state_d = IDLE;
                end
            end
            HEAT_ON, HEAT_OFF: begin
                if (!go_s) begin
                    // Stop wins over any simultaneous tick or window event.
                    state_d = OVERRUN;
                    ovr_d   = 8'd0;
                end else if (tick_s) begin
                    if (sec_inc_s == PERIOD_8) begin
                        start_s = 1'b1;
                        soft_d  = 1'b0;
                    end else begin
                        sec_d = sec_inc_s;
                        if ((state_q == HEAT_ON) && (sec_inc_s == on_ticks_s)) begin
                            state_d = HEAT_OFF;
                        end else begin
                            state_d = state_q;
                        end
                    end
                end else begin
                    state_d = state_q;
                end
            end
            OVERRUN: begin
                if (go_s) begin
                    // Restart from overrun is never a soft start.
                    start_s = 1'b1;
                    soft_d  = 1'b0;
                end else if (tick_s) begin
                    if (ovr_inc_s == FAN_8) begin
                        state_d = IDLE;
                        ovr_d   = 8'd0;
                    end else begin
                        ovr_d = ovr_inc_s;
                    end
                end else begin
                    state_d = OVERRUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Common window-start action: latch pot and restart the window.
        if (start_s) begin
            presc_d  = '0;
            sec_d    = 8'd0;
            pot_d    = pot;
            err_d    = ~pot_valid_f(pot);
            ws_d     = 1'b1;
            on_new_s = soft_d ? ON_LO_8 : on_ticks_f(pot);
            if (on_new_s != 8'd0) begin
                state_d = HEAT_ON;
            end else begin
                state_d = HEAT_OFF;
            end
        end else begin
            on_new_s = 8'd0;
        end

        mag_d  = (state_d == HEAT_ON);
        fan_d  = (state_d != IDLE);
        turn_d = (state_d == HEAT_ON) || (state_d == HEAT_OFF);
        lamp_d = (state_d == HEAT_ON) || (state_d == HEAT_OFF);
    end

    // State, counters and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            presc_q <= '0;
            sec_q   <= 8'd0;
            ovr_q   <= 8'd0;
            pot_q   <= 4'hA;
            err_q   <= 1'b0;
            soft_q  <= 1'b0;
            ws_q    <= 1'b0;
            mag_q   <= 1'b0;
            fan_q   <= 1'b0;
            turn_q  <= 1'b0;
            lamp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            sec_q   <= sec_d;
            ovr_q   <= ovr_d;
            pot_q   <= pot_d;
            err_q   <= err_d;
            soft_q  <= soft_d;
            ws_q    <= ws_d;
            mag_q   <= mag_d;
            fan_q   <= fan_d;
            turn_q  <= turn_d;
            lamp_q  <= lamp_d;
        end
    end

    // Door and reset gate the magnetron combinationally; lamp follows the door.
    assign magnetron    = mag_q & ~porta & ~reset;
    assign lamp         = lamp_q | porta;
    assign fan          = fan_q;
    assign turntable    = turn_q;
    assign window_start = ws_q;
    assign pot_err      = err_q;

endmodule

// File: tb/tb_magnetron_sched.sv
// Self-checking bench for magnetron_sched: directed scenarios followed by
// randomized input segments, checked against a window-time reference model.
module tb_magnetron_sched;

    localparam int TICK   = 4;
    localparam int PERIOD = 10;
    localparam int ON_LO  = 3;
    localparam int ON_MID = 6;
    localparam int FAN    = 3;

`ifdef MAG_SOFTSTART_EN
    localparam bit SOFT = 1'b1;
`else
    localparam bit SOFT = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic       run;
    logic       porta;
    logic [3:0] pot;
    logic       magnetron, fan, turntable, lamp, window_start, pot_err;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: mode 0 idle, 1 heating window, 2 overrun.
    int   m_mode  = 0;
    int   m_t     = 0;   // cycles since current window began
    int   m_on    = 0;   // on ticks of current window
    int   m_since = 0;   // cycles since prescaler was last cleared
    int   m_ovr   = 0;   // overrun ticks seen
    logic m_err   = 1'b0;
    logic m_ws    = 1'b0;

    int ws_seen  = 0;
    int mag_seen = 0;

    magnetron_sched #(
        .TICK_CYCLES  (TICK),
        .PERIOD_S     (PERIOD),
        .ON_LO        (ON_LO),
        .ON_MID       (ON_MID),
        .FAN_OVERRUN_S(FAN)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .porta       (porta),
        .pot         (pot),
        .magnetron   (magnetron),
        .fan         (fan),
        .turntable   (turntable),
        .lamp        (lamp),
        .window_start(window_start),
        .pot_err     (pot_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int on_of(input logic [3:0] p);
        if (p == 4'hA) return ON_LO;
        if (p == 4'hB) return ON_MID;
        if (p == 4'hC) return PERIOD;
        return 0;
    endfunction

    task automatic m_start(input bit from_idle);
        m_since = 0;
        m_t     = 0;
        m_on    = (SOFT && from_idle) ? ON_LO : on_of(pot);
        m_err   = !((pot == 4'hA) || (pot == 4'hB) || (pot == 4'hC));
        m_ws    = 1'b1;
        m_mode  = 1;
    endtask

    task automatic model_edge();
        bit tick;
        if (reset) begin
            m_mode = 0; m_since = 0; m_t = 0; m_ovr = 0; m_err = 1'b0; m_ws = 1'b0;
        end else begin
            tick = ((m_since % TICK) == TICK - 1);
            m_since++;
            m_ws = 1'b0;
            case (m_mode)
                0: if (run && !porta) m_start(1'b1);
                1: begin
                    if (!run || porta) begin
                        m_mode = 2;
                        m_ovr  = 0;
                    end else begin
                        m_t++;
                        if (m_t == PERIOD * TICK) m_start(1'b0);
                    end
                end
                2: begin
                    if (run && !porta) m_start(1'b0);
                    else if (tick) begin
                        m_ovr++;
                        if (m_ovr == FAN) m_mode = 0;
                    end
                end
                default: m_mode = 0;
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at t=%0t: observed %0b expected %0b", tag, $time, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic e_mag;
        e_mag = (m_mode == 1) && (m_t < m_on * TICK) && !porta && !reset;
        chk("magnetron",    magnetron,    e_mag);
        chk("fan",          fan,          m_mode != 0);
        chk("turntable",    turntable,    m_mode == 1);
        chk("lamp",         lamp,         (m_mode == 1) || porta);
        chk("window_start", window_start, m_ws);
        chk("pot_err",      pot_err,      m_err);
        if (window_start === 1'b1) ws_seen++;
        if (magnetron === 1'b1) mag_seen++;
    endtask

    // One cycle: drive inputs after negedge, check, then advance model at posedge.
    task automatic cycles(input int n, input logic r, input logic ru,
                          input logic pa, input logic [3:0] p);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            reset = r; run = ru; porta = pa; pot = p;
            #1;
            check_outputs();
            @(posedge clock);
            model_edge();
        end
    endtask

    logic [3:0] pot_tab [8];

    initial begin
        pot_tab = '{4'hA, 4'hB, 4'hC, 4'hA, 4'hB, 4'hC, 4'h7, 4'h0};
        reset = 1'b1; run = 1'b0; porta = 1'b0; pot = 4'hA;
        @(posedge clock);
        model_edge();
        cycles(3, 1'b1, 1'b0, 1'b0, 4'hA);
        cycles(3, 1'b0, 1'b0, 1'b1, 4'hA);   // idle lamp follows door

        // pot B, 100 cycles of run: windows at 1, 41, 81
        ws_seen = 0; mag_seen = 0;
        cycles(100, 1'b0, 1'b1, 1'b0, 4'hB);
        chk("ws_count_potB", ws_seen == 3, 1'b1);
`ifndef MAG_SOFTSTART_EN
        chk("mag_count_potB", mag_seen == 67, 1'b1);
`endif
        cycles(20, 1'b0, 1'b0, 1'b0, 4'hB);

        // pot C full-on, then change to A mid-window
        cycles(19, 1'b0, 1'b1, 1'b0, 4'hC);
        cycles(70, 1'b0, 1'b1, 1'b0, 4'hA);
        cycles(20, 1'b0, 1'b0, 1'b0, 4'hA);

        // door opens during HEAT_ON, then closes with run held
        cycles(9, 1'b0, 1'b1, 1'b0, 4'hB);
        cycles(20, 1'b0, 1'b1, 1'b1, 4'hB);
        cycles(10, 1'b0, 1'b1, 1'b0, 4'hB);
        cycles(20, 1'b0, 1'b0, 1'b0, 4'hB);

        // invalid pot, then valid A clears pot_err
        cycles(45, 1'b0, 1'b1, 1'b0, 4'h7);
        cycles(45, 1'b0, 1'b1, 1'b0, 4'hA);
        cycles(20, 1'b0, 1'b0, 1'b0, 4'hA);

        // reset mid-heat, run held high
        cycles(10, 1'b0, 1'b1, 1'b0, 4'hC);
        cycles(2, 1'b1, 1'b1, 1'b0, 4'hC);
        cycles(50, 1'b0, 1'b1, 1'b0, 4'hC);
        cycles(20, 1'b0, 1'b0, 1'b0, 4'hC);

        // run rises with door open, starts when door closes
        cycles(10, 1'b0, 1'b1, 1'b1, 4'hA);
        cycles(20, 1'b0, 1'b1, 1'b0, 4'hA);

        // randomized segments
        for (int s = 0; s < 200; s++) begin
            cycles($urandom_range(1, 50),
                   ($urandom_range(0, 39) == 0),
                   ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 4) == 0),
                   pot_tab[$urandom_range(0, 7)]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
